mem_wb_stage: RTL

Memory-access and write-back stage directly downstream of the 32-bit ALU. It accepts one retired ALU operation per handshake (opcode, condition flag, ALU result, address operand, destination register). It performs the LDR/STR data-memory transaction over a request/acknowledge bus and drives the register-file write port. Flag-only and suppressed operations retire without write-back.

---
 rtl/cpu_pkg.sv | 31 +++
 rtl/mem_timeout_counter.sv | 31 +++
 rtl/mem_wb_stage.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU/memory opcodes and the memory/write-back stage state.
package cpu_pkg;

    // Register-writing ALU operations occupy 0000-0111.
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_NOT = 4'b0101;
    localparam logic [3:0] OP_SHL = 4'b0110;
    localparam logic [3:0] OP_SHR = 4'b0111;
    // Flag-only compare, memory access, and no-op.
    localparam logic [3:0] OP_CMP = 4'b1000;
    localparam logic [3:0] OP_LDR = 4'b1001;
    localparam logic [3:0] OP_STR = 4'b1010;
    localparam logic [3:0] OP_NOP = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MEM_RD,
        ST_MEM_WR,
        ST_WB
    } mem_wb_state_t;

    // Word accesses must have the two low address bits clear.
    function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
        return addr_lsb == 2'b00;
    endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts memory-request cycles without an acknowledge; flags the last allowed cycle.
module mem_timeout_counter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic CLK,
    input  logic RESET,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam int unsigned WIDTH = $clog2(TIMEOUT_CYCLES + 1);

    logic [WIDTH-1:0] count;

    // Cycle counter: cleared when a request starts, advanced on every un-acked cycle.
    always_ff @(posedge CLK) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!RESET) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    // The current request cycle is the last one allowed before abort.
    assign terminal = (count == WIDTH'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_wb_stage.sv
// Memory-access / write-back stage: runs LDR/STR bus transactions and drives the
// register-file write port for ALU results and loaded data.
module mem_wb_stage
    import cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        IN_VALID,
    output logic        IN_READY,
    input  logic [3:0]  OPCODE,
    input  logic        CND_MET,
    input  logic [31:0] ALU_RESULT,
    input  logic [31:0] ADDR,
    input  logic [3:0]  DEST_REG,
    output logic [31:0] MEM_ADDR,
    output logic [31:0] MEM_WDATA,
    output logic        MEM_RE,
    output logic        MEM_WE,
    input  logic [31:0] MEM_RDATA,
    input  logic        MEM_ACK,
    output logic        WB_EN,
    output logic [3:0]  WB_REG,
    output logic [31:0] WB_DATA,
    output logic        DONE,
    output logic        ERR
);

    mem_wb_state_t state, state_n;
    logic [3:0]    dest, dest_n;
    logic [31:0]   mem_addr_n, mem_wdata_n, wb_data_n;
    logic [3:0]    wb_reg_n;
    logic          mem_re_n, mem_we_n, wb_en_n, done_n, err_n;
    logic          cnt_clear, cnt_en, cnt_tc;

    mem_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .CLK     (CLK),
        .RESET   (RESET),
        .clear   (cnt_clear),
        .enable  (cnt_en),
        .terminal(cnt_tc)
    );

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_n     = state;
        dest_n      = dest;
        mem_addr_n  = MEM_ADDR;
        mem_wdata_n = MEM_WDATA;
        mem_re_n    = MEM_RE;
        mem_we_n    = MEM_WE;
        wb_reg_n    = WB_REG;
        wb_data_n   = WB_DATA;
        wb_en_n     = 1'b0;
        done_n      = 1'b0;
        err_n       = 1'b0;
        cnt_clear   = 1'b0;
        cnt_en      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (IN_VALID) begin
                    if (!CND_MET) begin
                        // Condition failed: retire with no side effects.
                        done_n = 1'b1;
                    end else begin
                        case (OPCODE)
                            OP_ADD, OP_SUB, OP_AND, OP_OR,
                            OP_XOR, OP_NOT, OP_SHL, OP_SHR: begin
                                state_n   = ST_WB;
                                wb_en_n   = 1'b1;
                                done_n    = 1'b1;
                                wb_reg_n  = DEST_REG;
                                wb_data_n = ALU_RESULT;
                            end
                            OP_LDR: begin
                                if (!is_word_aligned(ADDR[1:0])) begin
                                    err_n  = 1'b1;
                                    done_n = 1'b1;
                                end else begin
                                    state_n    = ST_MEM_RD;
                                    mem_re_n   = 1'b1;
                                    mem_addr_n = ADDR;
                                    dest_n     = DEST_REG;
                                    cnt_clear  = 1'b1;
                                end
                            end
                            OP_STR: begin
                                if (!is_word_aligned(ADDR[1:0])) begin
                                    err_n  = 1'b1;
                                    done_n = 1'b1;
                                end else begin
                                    state_n     = ST_MEM_WR;
                                    mem_we_n    = 1'b1;
                                    mem_addr_n  = ADDR;
                                    mem_wdata_n = ALU_RESULT;
                                    cnt_clear   = 1'b1;
                                end
                            end
                            OP_CMP, OP_NOP: done_n = 1'b1;
                            default:        done_n = 1'b1;
                        endcase
                    end
                end
            end
            ST_MEM_RD: begin
                // An acknowledge on the terminal cycle still completes the load.
                if (MEM_ACK) begin
                    state_n   = ST_WB;
                    mem_re_n  = 1'b0;
                    wb_en_n   = 1'b1;
                    done_n    = 1'b1;
                    wb_reg_n  = dest;
                    wb_data_n = MEM_RDATA;
                end else if (cnt_tc) begin
                    state_n  = ST_IDLE;
                    mem_re_n = 1'b0;
                    err_n    = 1'b1;
                    done_n   = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_MEM_WR: begin
                if (MEM_ACK) begin
                    state_n  = ST_IDLE;
                    mem_we_n = 1'b0;
                    done_n   = 1'b1;
                end else if (cnt_tc) begin
                    state_n  = ST_IDLE;
                    mem_we_n = 1'b0;
                    err_n    = 1'b1;
                    done_n   = 1'b1;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            ST_WB:   state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state     <= ST_IDLE;
            dest      <= '0;
            IN_READY  <= 1'b1;
            MEM_ADDR  <= '0;
            MEM_WDATA <= '0;
            MEM_RE    <= 1'b0;
            MEM_WE    <= 1'b0;
            WB_EN     <= 1'b0;
            WB_REG    <= '0;
            WB_DATA   <= '0;
            DONE      <= 1'b0;
            ERR       <= 1'b0;
        end else begin
            state     <= state_n;
            dest      <= dest_n;
            IN_READY  <= (state_n == ST_IDLE);
            MEM_ADDR  <= mem_addr_n;
            MEM_WDATA <= mem_wdata_n;
            MEM_RE    <= mem_re_n;
            MEM_WE    <= mem_we_n;
            WB_EN     <= wb_en_n;
            WB_REG    <= wb_reg_n;
            WB_DATA   <= wb_data_n;
            DONE      <= done_n;
            ERR       <= err_n;
        end
    end

endmodule
